uart_cmd_bridge: RTL and testbench

//  Host-side command engine on the FIFO interface of the uart block. Pops bytes from
//  the RX FIFO, parses write/read packets, issues single-word accesses on a simple

---
 rtl/uart_cmd_bridge_if.sv | 30 +++
 rtl/uart_cmd_bridge.sv | 124 ++++++++++++
 tb/tb_uart_cmd_bridge.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_bridge_if.sv
// Bridge-side bundle: uart FIFO handshake, memory port and status flags.
interface uart_cmd_bridge_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              rx_empty;
  logic [7:0]        r_data;
  logic              rd_uart;
  logic              tx_full;
  logic              wr_uart;
  logic [7:0]        w_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              cmd_err;
  logic              busy;

  modport master (
    input  rx_empty, r_data, tx_full, mem_rdata,
    output rd_uart, wr_uart, w_data, mem_addr, mem_wdata, mem_we, mem_re,
           cmd_err, busy
  );

  modport slave (
    output rx_empty, r_data, tx_full, mem_rdata,
    input  rd_uart, wr_uart, w_data, mem_addr, mem_wdata, mem_we, mem_re,
           cmd_err, busy
  );
endinterface

// File: rtl/uart_cmd_bridge.sv
// Serial command engine: parses 'W'/'R' packets from the uart RX FIFO,
// performs one 32-bit memory access per packet and replies via the TX FIFO.
module uart_cmd_bridge #(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [7:0]  CMD_WR   = 8'h57,
  parameter logic [7:0]  CMD_RD   = 8'h52,
  parameter logic [7:0]  ACK_BYTE = 8'h06
) (
  input  logic            clk,
  input  logic            reset,
  uart_cmd_bridge_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    SEND_ACK,
    READ,
    WAIT_RD,
    SEND_DATA
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  cnt;
  logic        is_rd;
  logic [31:0] shreg;
  logic        pop, push;
  logic        opcode_ok;

  assign opcode_ok = (bus.r_data == CMD_WR) || (bus.r_data == CMD_RD);

  // FIFO strobes are combinational so a byte can move every cycle
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    if (!reset && !bus.rx_empty &&
        (state == IDLE || state == GET_ADDR || state == GET_DATA))
      pop = 1'b1;
    if (!reset && !bus.tx_full && (state == SEND_ACK || state == SEND_DATA))
      push = 1'b1;
  end

  assign bus.rd_uart = pop;
  assign bus.wr_uart = push;
  assign bus.mem_we  = (state == WRITE);
  assign bus.mem_re  = (state == READ);
  assign bus.busy    = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (pop && opcode_ok) state_nx = GET_ADDR;
      GET_ADDR:  if (pop) state_nx = is_rd ? READ : GET_DATA;
      GET_DATA:  if (pop && cnt == 2'd3) state_nx = WRITE;
      WRITE:     state_nx = SEND_ACK;
      SEND_ACK:  if (push) state_nx = IDLE;
      READ:      state_nx = WAIT_RD;
      WAIT_RD:   state_nx = SEND_DATA;
      SEND_DATA: if (push && cnt == 2'd3) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Datapath: packet fields, reply byte and read shift register.
  // w_data is loaded one step ahead so it already holds the byte to push
  // whenever a send state is active (equivalent to driving shreg[7:0]).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      is_rd         <= 1'b0;
      shreg         <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.w_data    <= '0;
      bus.cmd_err   <= 1'b0;
    end else begin
      bus.cmd_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            if (opcode_ok) is_rd <= (bus.r_data == CMD_RD);
            else           bus.cmd_err <= 1'b1;
          end
        end
        GET_ADDR: begin
          if (pop) begin
            bus.mem_addr <= ADDR_W'(bus.r_data);
            cnt          <= '0;
          end
        end
        GET_DATA: begin
          if (pop) begin
            bus.mem_wdata[{cnt, 3'b000} +: 8] <= bus.r_data;
            cnt <= cnt + 2'd1;
          end
        end
        WRITE: bus.w_data <= ACK_BYTE;
        WAIT_RD: begin
          shreg      <= bus.mem_rdata;
          bus.w_data <= bus.mem_rdata[7:0];
          cnt        <= '0;
        end
        SEND_DATA: begin
          if (push) begin
            shreg      <= {8'h00, shreg[31:8]};
            bus.w_data <= shreg[15:8];
            cnt        <= cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge with RX/TX FIFO and memory models.
module tb_uart_cmd_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_cmd_bridge_if #(.ADDR_W(8)) bus ();

  uart_cmd_bridge #(
    .ADDR_W  (8),
    .CMD_WR  (8'h57),
    .CMD_RD  (8'h52),
    .ACK_BYTE(8'h06)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // RX FIFO model (show-ahead)
  logic [7:0] rx_mem [256];
  int         rx_wp = 0;
  int         rx_rp = 0;
  logic       tx_full_r = 1'b0;
  assign bus.rx_empty = (rx_wp == rx_rp);
  assign bus.r_data   = rx_mem[rx_rp[7:0]];
  assign bus.tx_full  = tx_full_r;

  // Logs of memory accesses, TX bytes and status events
  logic [31:0] mem [256];
  logic [31:0] rdata_q = '0;
  logic        acc_rd   [64];
  logic [7:0]  acc_addr [64];
  logic [31:0] acc_data [64];
  int          acc_cyc  [64];
  logic [7:0]  tx_log   [64];
  int          tx_cyc   [64];
  int acc_n = 0, tx_n = 0, err_n = 0, viol_n = 0, cyc = 0, last_pop = 0;

  assign bus.mem_rdata = rdata_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rd_uart) begin
      rx_rp    <= rx_rp + 1;
      last_pop <= cyc;
    end
    if (bus.wr_uart) begin
      tx_log[tx_n] <= bus.w_data;
      tx_cyc[tx_n] <= cyc;
      tx_n         <= tx_n + 1;
      if (tx_full_r) viol_n <= viol_n + 1;
    end
    if (bus.mem_we || bus.mem_re) begin
      acc_rd[acc_n]   <= bus.mem_re;
      acc_addr[acc_n] <= bus.mem_addr;
      acc_data[acc_n] <= bus.mem_wdata;
      acc_cyc[acc_n]  <= cyc;
      acc_n           <= acc_n + 1;
    end
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) rdata_q <= mem[bus.mem_addr];
    if (bus.cmd_err) err_n <= err_n + 1;
  end

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wp[7:0]] = b;
    rx_wp++;
  endtask

  task automatic wait_idle(input string tag);
    int ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rx_wp == rx_rp && !bus.busy) begin
        ok = 1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  task automatic chk_acc(input string tag, input int idx, input logic rd,
                         input logic [7:0] addr, input logic [31:0] data);
    check({tag, "_kind"}, {31'b0, acc_rd[idx]}, {31'b0, rd});
    check({tag, "_addr"}, {24'b0, acc_addr[idx]}, {24'b0, addr});
    if (!rd) check({tag, "_wdata"}, acc_data[idx], data);
  endtask

  task automatic chk_tx(input string tag, input int base, input logic [31:0] bytes4);
    logic [31:0] v;
    v = bytes4;
    for (int unsigned k = 0; k < 4; k++) begin
      check($sformatf("%s_b%0d", tag, k), {24'b0, tx_log[base + int'(k)]}, {24'b0, v[7:0]});
      v = v >> 8;
    end
  endtask

  int a0, t0, e0;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",  {31'b0, bus.busy},    0);
    check("rst_rd",    {31'b0, bus.rd_uart}, 0);
    check("rst_wr",    {31'b0, bus.wr_uart}, 0);
    check("rst_we",    {31'b0, bus.mem_we},  0);
    check("rst_addr",  {24'b0, bus.mem_addr}, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_wdat8", {24'b0, bus.w_data},  0);
    check("rst_err",   {31'b0, bus.cmd_err}, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: write packet, plus latency
    a0 = acc_n; t0 = tx_n;
    push_rx(8'h57); push_rx(8'h10); push_rx(8'hEF);
    push_rx(8'hBE); push_rx(8'hAD); push_rx(8'hDE);
    wait_idle("t1_idle");
    check("t1_nacc", acc_n - a0, 1);
    chk_acc("t1", a0, 1'b0, 8'h10, 32'hDEADBEEF);
    check("t1_we_lat", acc_cyc[a0] - last_pop, 1);
    check("t1_ntx", tx_n - t0, 1);
    check("t1_ack", {24'b0, tx_log[t0]}, 32'h06);
    check("t1_ack_lat", tx_cyc[t0] - acc_cyc[a0], 1);

    // 2: load 0x20 then read it back
    push_rx(8'h57); push_rx(8'h20); push_rx(8'h78);
    push_rx(8'h56); push_rx(8'h34); push_rx(8'h12);
    wait_idle("t2_load");
    a0 = acc_n; t0 = tx_n;
    push_rx(8'h52); push_rx(8'h20);
    wait_idle("t2_idle");
    check("t2_nacc", acc_n - a0, 1);
    chk_acc("t2", a0, 1'b1, 8'h20, 32'h0);
    check("t2_re_lat", acc_cyc[a0] - last_pop, 1);
    check("t2_ntx", tx_n - t0, 4);
    check("t2_tx_lat", tx_cyc[t0] - acc_cyc[a0], 2);
    chk_tx("t2", t0, 32'h12345678);

    // 3: bad opcode dropped, following read proceeds
    push_rx(8'h57); push_rx(8'h05); push_rx(8'h44);
    push_rx(8'h33); push_rx(8'h22); push_rx(8'h11);
    wait_idle("t3_load");
    a0 = acc_n; t0 = tx_n; e0 = err_n;
    push_rx(8'h41); push_rx(8'h52); push_rx(8'h05);
    wait_idle("t3_idle");
    check("t3_err", err_n - e0, 1);
    check("t3_nacc", acc_n - a0, 1);
    chk_acc("t3", a0, 1'b1, 8'h05, 32'h0);
    check("t3_ntx", tx_n - t0, 4);
    chk_tx("t3", t0, 32'h11223344);

    // 4a: TX backpressure during read reply
    a0 = acc_n; t0 = tx_n;
    tx_full_r = 1'b1;
    push_rx(8'h52); push_rx(8'h20);
    repeat (50) @(negedge clk);
    check("t4_stall_tx", tx_n - t0, 0);
    check("t4_stall_busy", {31'b0, bus.busy}, 1);
    tx_full_r = 1'b0;
    wait_idle("t4_idle");
    check("t4_viol", viol_n, 0);
    check("t4_ntx", tx_n - t0, 4);
    chk_tx("t4", t0, 32'h12345678);

    // 4b: RX gaps between write bytes
    a0 = acc_n; t0 = tx_n;
    begin
      logic [7:0] pkt [6] = '{8'h57, 8'h30, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      int         gap [6] = '{1, 20, 3, 7, 12, 5};
      for (int i = 0; i < 6; i++) begin
        repeat (gap[i]) @(negedge clk);
        push_rx(pkt[i]);
      end
    end
    wait_idle("t4b_idle");
    check("t4b_nacc", acc_n - a0, 1);
    chk_acc("t4b", a0, 1'b0, 8'h30, 32'hDEADBEEF);
    check("t4b_ntx", tx_n - t0, 1);
    check("t4b_ack", {24'b0, tx_log[t0]}, 32'h06);

    // 5: reset mid-packet aborts it
    a0 = acc_n; t0 = tx_n;
    push_rx(8'h57); push_rx(8'h10); push_rx(8'hAA);
    repeat (5) @(negedge clk);
    check("t5_busy_pre", {31'b0, bus.busy}, 1);
    reset = 1'b1;
    #1;
    check("t5_busy_rst", {31'b0, bus.busy}, 0);
    check("t5_we_rst",   {31'b0, bus.mem_we}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_nacc_abort", acc_n - a0, 0);
    check("t5_ntx_abort",  tx_n - t0, 0);
    push_rx(8'h57); push_rx(8'h40); push_rx(8'h0D);
    push_rx(8'h0C); push_rx(8'h0B); push_rx(8'h0A);
    wait_idle("t5_idle");
    check("t5_nacc", acc_n - a0, 1);
    chk_acc("t5", a0, 1'b0, 8'h40, 32'h0A0B0C0D);
    check("t5_ack", {24'b0, tx_log[t0]}, 32'h06);

    // 6: back-to-back W, R, W preloaded (opcode-valued bytes as data)
    a0 = acc_n; t0 = tx_n;
    push_rx(8'h57); push_rx(8'h50); push_rx(8'h57);
    push_rx(8'h52); push_rx(8'h03); push_rx(8'h04);
    push_rx(8'h52); push_rx(8'h50);
    push_rx(8'h57); push_rx(8'h51); push_rx(8'hA0);
    push_rx(8'hB0); push_rx(8'hC0); push_rx(8'hD0);
    wait_idle("t6_idle");
    check("t6_nacc", acc_n - a0, 3);
    chk_acc("t6_a0", a0,     1'b0, 8'h50, 32'h04035257);
    chk_acc("t6_a1", a0 + 1, 1'b1, 8'h50, 32'h0);
    chk_acc("t6_a2", a0 + 2, 1'b0, 8'h51, 32'hD0C0B0A0);
    check("t6_ntx", tx_n - t0, 6);
    check("t6_ack0", {24'b0, tx_log[t0]}, 32'h06);
    chk_tx("t6_rd", t0 + 1, 32'h04035257);
    check("t6_ack1", {24'b0, tx_log[t0 + 5]}, 32'h06);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
